// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - unsigned ALU with single-cycle logic/add ops and iterative MUL/DIV
// Shift-add multiply and restoring divide run WIDTH iterations in EXEC; everything else completes at acceptance.
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [WIDTH-1:0] inputR1,
  input  logic [WIDTH-1:0] inputR2,
  input  logic [2:0]       instruction,
  input  logic             start,
  output logic [WIDTH-1:0] outputR,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               is_div, is_div_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [2*WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [WIDTH-1:0]   rem, rem_nxt;
  logic [WIDTH-1:0]   quo, quo_nxt;
  logic [WIDTH-1:0]   dvsr, dvsr_nxt;
  logic [WIDTH-1:0]   res_nxt;
  logic               busy_nxt, done_nxt, zero_nxt, carry_nxt, div0_nxt;

  logic [WIDTH:0]     add_w, sub_w;
  logic [WIDTH-1:0]   fast_res;
  logic               fast_carry, fast_div0, fast_op;

  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_step, quo_step;

  assign add_w = {1'b0, inputR1} + {1'b0, inputR2};
  assign sub_w = {1'b0, inputR1} - {1'b0, inputR2};

  // Result of anything that finishes on the accepting edge, including DIV by zero
  always_comb begin
    fast_res   = '0;
    fast_carry = 1'b0;
    fast_div0  = 1'b0;
    fast_op    = 1'b1;
    case (instruction)
      OP_ADD: begin
        fast_res   = add_w[WIDTH-1:0];
        fast_carry = add_w[WIDTH];
      end
      OP_SUB: begin
        fast_res   = sub_w[WIDTH-1:0];
        fast_carry = sub_w[WIDTH];
      end
      OP_AND:  fast_res = inputR1 & inputR2;
      OP_OR:   fast_res = inputR1 | inputR2;
      OP_XOR:  fast_res = inputR1 ^ inputR2;
      OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (inputR1 < inputR2)};
      OP_MUL:  fast_op  = 1'b0;
      OP_DIV: begin
        if (inputR2 == '0) begin
          fast_res  = '1;
          fast_div0 = 1'b1;
        end else begin
          fast_op = 1'b0;
        end
      end
      default: fast_op = 1'b1;
    endcase
  end

  // One iteration of each multi-cycle algorithm, from the current working registers
  always_comb begin
    mul_step  = acc + (mplier[0] ? mcand : '0);
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvsr};
    div_ok    = ~div_diff[WIDTH];
    rem_step  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_step  = {quo[WIDTH-2:0], div_ok};
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    is_div_nxt = is_div;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    rem_nxt    = rem;
    quo_nxt    = quo;
    dvsr_nxt   = dvsr;
    res_nxt    = outputR;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    zero_nxt   = zero;
    carry_nxt  = carry;
    div0_nxt   = div0;
    case (state)
      IDLE: begin
        if (start) begin
          if (fast_op) begin
            res_nxt   = fast_res;
            carry_nxt = fast_carry;
            div0_nxt  = fast_div0;
            zero_nxt  = (fast_res == '0);
            done_nxt  = 1'b1;
          end else begin
            state_nxt  = EXEC;
            busy_nxt   = 1'b1;
            cnt_nxt    = '0;
            is_div_nxt = (instruction == OP_DIV);
            acc_nxt    = '0;
            mcand_nxt  = {{WIDTH{1'b0}}, inputR1};
            mplier_nxt = inputR2;
            rem_nxt    = '0;
            quo_nxt    = inputR1;
            dvsr_nxt   = inputR2;
          end
        end
      end
      EXEC: begin
        cnt_nxt    = cnt + 1'b1;
        acc_nxt    = mul_step;
        mcand_nxt  = {mcand[2*WIDTH-2:0], 1'b0};
        mplier_nxt = {1'b0, mplier[WIDTH-1:1]};
        rem_nxt    = rem_step;
        quo_nxt    = quo_step;
        // Final iteration: publish straight from the step logic so the result lands on edge k+WIDTH
        if (cnt == LAST) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          div0_nxt  = 1'b0;
          cnt_nxt   = '0;
          if (is_div) begin
            res_nxt   = quo_step;
            carry_nxt = 1'b0;
            zero_nxt  = (quo_step == '0);
          end else begin
            res_nxt   = mul_step[WIDTH-1:0];
            carry_nxt = |mul_step[2*WIDTH-1:WIDTH];
            zero_nxt  = (mul_step[WIDTH-1:0] == '0);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      outputR <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      div0    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      is_div  <= is_div_nxt;
      acc     <= acc_nxt;
      mcand   <= mcand_nxt;
      mplier  <= mplier_nxt;
      rem     <= rem_nxt;
      quo     <= quo_nxt;
      dvsr    <= dvsr_nxt;
      outputR <= res_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      zero    <= zero_nxt;
      carry   <= carry_nxt;
      div0    <= div0_nxt;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle at WIDTH=16 and WIDTH=8
module tb_alu_multicycle;

  logic        CK = 1'b0;
  logic        RST;
  logic [15:0] r1, r2, out16;
  logic [2:0]  instr;
  logic        start, busy16, done16, zero16, carry16, div016;
  logic [7:0]  a8, b8, out8;
  logic [2:0]  instr8;
  logic        start8, busy8, done8, zero8, carry8, div08;

  int n_cmp = 0;
  int n_err = 0;
  longint unsigned prev16 = 0;
  longint unsigned prev8 = 0;

  always #5 CK = ~CK;

  alu_multicycle #(.WIDTH(16)) dut16 (
    .CK(CK), .RST(RST), .inputR1(r1), .inputR2(r2), .instruction(instr), .start(start),
    .outputR(out16), .busy(busy16), .done(done16), .zero(zero16), .carry(carry16), .div0(div016)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .CK(CK), .RST(RST), .inputR1(a8), .inputR2(b8), .instruction(instr8), .start(start8),
    .outputR(out8), .busy(busy8), .done(done8), .zero(zero8), .carry(carry8), .div0(div08)
  );

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands, plus the cycle count until completion
  function automatic void model(input int w, input logic [2:0] op, input longint unsigned a,
                                input longint unsigned b, output longint unsigned res,
                                output bit cy, output bit d0, output int lat);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned p;
    cy = 0; d0 = 0; lat = 0; res = 0;
    case (op)
      3'd0: begin p = a + b; res = p & mask; cy = (p > mask); end
      3'd1: begin res = (a - b) & mask; cy = (a < b); end
      3'd2: res = a & b;
      3'd3: begin p = a * b; res = p & mask; cy = ((p >> w) != 0); lat = w; end
      3'd4: res = a | b;
      3'd5: res = a ^ b;
      3'd6: begin
        if (b == 0) begin res = mask; d0 = 1; end
        else begin res = a / b; lat = w; end
      end
      default: res = (a < b) ? 1 : 0;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input string tag);
    longint unsigned er;
    bit ec, ed;
    int lat, bad;
    model(16, op, a, b, er, ec, ed, lat);
    @(negedge CK);
    r1 = a; r2 = b; instr = op; start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    r1 = 16'($urandom); r2 = 16'($urandom); instr = 3'($urandom);
    if (lat != 0) begin
      check({tag, "/busy_k"}, busy16, 1);
      check({tag, "/done_k"}, done16, 0);
      bad = 0;
      for (int i = 1; i < lat; i++) begin
        @(posedge CK); #1;
        if (busy16 !== 1'b1 || done16 !== 1'b0 || out16 !== 16'(prev16)) bad++;
      end
      check({tag, "/exec_hold"}, bad, 0);
      @(posedge CK); #1;
    end
    check({tag, "/res"}, out16, er);
    check({tag, "/carry"}, carry16, ec);
    check({tag, "/div0"}, div016, ed);
    check({tag, "/zero"}, zero16, (er == 0));
    check({tag, "/done"}, done16, 1);
    check({tag, "/busy"}, busy16, 0);
    prev16 = er;
    @(posedge CK); #1;
    check({tag, "/done_off"}, done16, 0);
  endtask

  task automatic do_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
    longint unsigned er;
    bit ec, ed;
    int lat, bad;
    model(8, op, a, b, er, ec, ed, lat);
    @(negedge CK);
    a8 = a; b8 = b; instr8 = op; start8 = 1'b1;
    @(posedge CK); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    bad = 0;
    for (int i = 1; i <= lat; i++) begin
      if (busy8 !== 1'b1 || done8 !== 1'b0 || out8 !== 8'(prev8)) bad++;
      @(posedge CK); #1;
    end
    check({tag, "/exec_hold"}, bad, 0);
    check({tag, "/res"}, out8, er);
    check({tag, "/carry"}, carry8, ec);
    check({tag, "/div0"}, div08, ed);
    check({tag, "/zero"}, zero8, (er == 0));
    check({tag, "/done"}, done8, 1);
    check({tag, "/busy"}, busy8, 0);
    prev8 = er;
  endtask

  initial begin
    int bad, saw_done;
    logic [2:0] op;
    logic [15:0] ra, rb;
    RST = 1'b1; start = 1'b0; r1 = '0; r2 = '0; instr = '0;
    start8 = 1'b0; a8 = '0; b8 = '0; instr8 = '0;
    repeat (3) @(posedge CK);
    #1;
    check("rst/out", out16, 0);
    check("rst/flags", {busy16, done16, zero16, carry16, div016}, 0);
    check("rst/out8", {out8, busy8, done8, zero8, carry8, div08}, 0);
    @(negedge CK);
    RST = 1'b0;

    do_op(3'd0, 16'hFFFF, 16'h0001, "add_wrap");
    do_op(3'd3, 16'h000A, 16'h0009, "mul_a_9");
    do_op(3'd6, 16'h0064, 16'h0007, "div_100_7");
    do_op(3'd6, 16'h1234, 16'h0000, "div_by0");
    do_op(3'd2, 16'hF0F0, 16'h0FF0, "and_clr_div0");
    do_op(3'd7, 16'h0003, 16'h0005, "sltu");
    do_op(3'd3, 16'hFFFF, 16'hFFFF, "mul_ovf");
    do_op(3'd6, 16'h0003, 16'h0009, "div_small");

    // SUB presented with start held high throughout a MUL must be ignored
    @(negedge CK);
    r1 = 16'h000A; r2 = 16'h0009; instr = 3'd3; start = 1'b1;
    @(posedge CK); #1;
    r1 = 16'h0003; r2 = 16'h0005; instr = 3'd1;
    check("ign/busy_k", busy16, 1);
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      @(posedge CK); #1;
      if (busy16 !== 1'b1 || done16 !== 1'b0) bad++;
    end
    check("ign/exec", bad, 0);
    @(posedge CK); #1;
    start = 1'b0;
    check("ign/res", out16, 16'h005A);
    check("ign/carry", carry16, 0);
    check("ign/done", done16, 1);
    @(posedge CK); #1;
    check("ign/after", {done16, busy16, out16}, {2'b00, 16'h005A});
    prev16 = 16'h005A;
    do_op(3'd1, 16'h0003, 16'h0005, "sub_borrow");

    // Reset 5 cycles into a MUL aborts it silently
    @(negedge CK);
    r1 = 16'h0123; r2 = 16'h0456; instr = 3'd3; start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    repeat (4) @(posedge CK);
    @(negedge CK);
    RST = 1'b1;
    @(posedge CK); #1;
    check("abort/busy", busy16, 0);
    check("abort/out", out16, 0);
    check("abort/done", done16, 0);
    @(negedge CK);
    RST = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CK); #1;
      if (done16 === 1'b1 || busy16 === 1'b1) saw_done++;
    end
    check("abort/quiet", saw_done, 0);
    prev16 = 0; prev8 = 0;
    do_op(3'd0, 16'h0002, 16'h0003, "add_after_rst");

    // Back-to-back: an ADD waiting on start is taken on the edge after MUL completes
    @(negedge CK);
    r1 = 16'h0003; r2 = 16'h0004; instr = 3'd3; start = 1'b1;
    @(posedge CK); #1;
    r1 = 16'h0005; r2 = 16'h0006; instr = 3'd0;
    repeat (15) @(posedge CK);
    @(posedge CK); #1;
    check("b2b/mul", {done16, out16}, {1'b1, 16'h000C});
    @(posedge CK); #1;
    start = 1'b0;
    check("b2b/add", {done16, busy16, out16}, {2'b10, 16'h000B});
    prev16 = 16'h000B;

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom);
      ra = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      do_op(op, ra, rb, $sformatf("rnd%0d_op%0d", n, op));
    end

    do_op8(3'd3, 8'h10, 8'h10, "w8_mul_ovf");
    do_op8(3'd6, 8'hFF, 8'h03, "w8_div");
    do_op8(3'd6, 8'h12, 8'h00, "w8_div0");
    for (int n = 0; n < 12; n++) begin
      op = 3'($urandom);
      do_op8(op, 8'($urandom), 8'($urandom), $sformatf("w8rnd%0d_op%0d", n, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
